// File: rtl/mem_bus_master.sv
// Single-outstanding memory bus master with a shared tri-state data bus.
// Reads, full writes and byte-strobed writes.
// Partial writes are done as read-modify-write.
// Out-of-range addresses and zero-strobe writes answer immediately without
// touching the bus.

// One byte lane of the read-modify-write merge: take the new byte when enabled.
module mem_bus_byte_merge #(
    parameter int VEC_W = 8
) (
    input  logic             en,
    input  logic [VEC_W-1:0] old_b,
    input  logic [VEC_W-1:0] new_b,
    output logic [VEC_W-1:0] out_b
);
    assign out_b = en ? new_b : old_b;
endmodule

module mem_bus_master #(
    parameter int unsigned ADDR_MAX = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam logic [31:0] ADDR_LIM = 32'(ADDR_MAX);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RSP} state_t;

    // Write payload held across the read half of a read-modify-write.
    typedef struct packed {
        logic [NUM_LANES-1:0][VEC_W-1:0] wdata;
        logic [NUM_LANES-1:0]            wstrb;
    } wr_lat_t;

    state_t                          state;
    wr_lat_t                         wr_q;
    logic [31:0]                     drive_q;
    logic [NUM_LANES-1:0][VEC_W-1:0] bus_in;
    logic [NUM_LANES-1:0][VEC_W-1:0] merged;

    // mem_we is the drive enable too, so the bus turns around on one flop.
    assign mem_data = mem_we ? drive_q : 'z;
    assign bus_in   = mem_data;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            mem_bus_byte_merge #(.VEC_W(VEC_W)) u_merge (
                .en    (wr_q.wstrb[g]),
                .old_b (bus_in[g]),
                .new_b (wr_q.wdata[g]),
                .out_b (merged[g])
            );
        end
    endgenerate

    // Transaction FSM; every output is a flop so nothing glitches onto the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            drive_q   <= '0;
            wr_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        rsp_err   <= 1'b0;
                        if (req_addr > ADDR_LIM) begin
                            // Out of range: answer at once, bus untouched.
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (!req_we) begin
                            state    <= RD;
                            mem_addr <= req_addr;
                            mem_we   <= 1'b0;
                        end else if (req_wstrb == 4'b1111) begin
                            state    <= WR;
                            mem_addr <= req_addr;
                            mem_we   <= 1'b1;
                            drive_q  <= req_wdata;
                        end else if (req_wstrb == 4'b0000) begin
                            // Nothing to write: acknowledge without bus activity.
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state      <= RMW_RD;
                            mem_addr   <= req_addr;
                            mem_we     <= 1'b0;
                            wr_q.wdata <= req_wdata;
                            wr_q.wstrb <= req_wstrb;
                        end
                    end
                end
                RD: begin
                    rsp_rdata <= mem_data;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RMW_RD: begin
                    drive_q <= merged;
                    mem_we  <= 1'b1;
                    state   <= WR;
                end
                WR: begin
                    mem_we    <= 1'b0;
                    rsp_rdata <= drive_q;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
